// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared types and default timing for the traffic request
//               controller: per-channel state enum, channel indices and
//               default debounce / retry constants.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    // Request channel life cycle
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        SERVED = 2'd3
    } chan_state_t;

    localparam int unsigned c_debounce_cycles_def = 4;
    localparam int unsigned c_retry_cycles_def    = 400;
    localparam int unsigned c_max_retries_def     = 3;

    // Channel indices inside the per-channel vectors
    localparam int unsigned c_ch_ped = 0;
    localparam int unsigned c_ch_emg = 1;
    localparam int unsigned c_num_ch = 2;

endpackage
`default_nettype wire

// File: rtl/traffic_debounce.sv
`default_nettype none
// ============================================================================
// Module      : traffic_debounce
// Description : Two-flop synchronizer, stable-sample counter and rising-edge
//               detector for one raw push-button. o_rise pulses for one cycle
//               when the debounced level changes from 0 to 1.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_debounce
    import traffic_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_debounce_cycles_def
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_rise
);

    // Counter value on the sample that completes the stable run
    localparam logic [7:0] c_last = 8'(DEBOUNCE_CYCLES - 1);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_stable;
    logic [7:0] r_cnt;

    // Bring the asynchronous button into the clock domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive samples that disagree with the debounced level; flip the level once enough agree
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stable <= 1'b0;
            r_cnt    <= 8'd0;
            o_rise   <= 1'b0;
        end else begin
            o_rise <= 1'b0;
            if (r_sync2 == r_stable) begin
                r_cnt <= 8'd0;
            end else if (r_cnt == c_last) begin
                r_stable <= r_sync2;
                r_cnt    <= 8'd0;
                o_rise   <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/traffic_request_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : traffic_request_ctrl
// Description : Turns debounced pedestrian / emergency button presses into
//               one-cycle request pulses for the traffic controller and tracks
//               each request until the controller's service light answers.
//               Emergency wins a same-cycle collision; pedestrian follows one
//               cycle later.
//               Build option TRAFFIC_REQ_RETRY_EN: re-issue unanswered requests
//               every RETRY_CYCLES and raise a sticky fault after MAX_RETRIES.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_request_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_debounce_cycles_def,
    parameter int unsigned RETRY_CYCLES    = c_retry_cycles_def,
    parameter int unsigned MAX_RETRIES     = c_max_retries_def
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ped_raw,
    input  logic       emg_raw,
    input  logic       pedestrian_light,
    input  logic       emergency_light,
    output logic       pedestrian_button,
    output logic       emergency_button,
    output logic       ped_pending,
    output logic       emg_pending,
    output logic [1:0] req_fault
);

    // An out-of-range configuration never accepts a press
    localparam bit c_cfg_ok = (DEBOUNCE_CYCLES >= 1) && (DEBOUNCE_CYCLES <= 255) &&
                              (RETRY_CYCLES >= 2)    && (RETRY_CYCLES <= 65535) &&
                              (MAX_RETRIES >= 1)     && (MAX_RETRIES <= 15);

    logic [1:0] w_raw;
    logic [1:0] w_light;
    logic [1:0] w_rise;
    logic [1:0] w_accept;
    logic [1:0] w_enter_issue;
    logic [1:0] w_button;
    logic [1:0] w_pending;
    logic [1:0] w_fault;

    assign w_raw   = {emg_raw, ped_raw};
    assign w_light = {emergency_light, pedestrian_light};

    generate
        for (genvar g = 0; g < c_num_ch; g++) begin : g_ch
            chan_state_t r_state;
            logic        r_button;
            logic        r_pending;
            logic        w_hold;
            logic        w_reissue;
            logic        w_give_up;

            traffic_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk   (clk),
                .rst   (reset),
                .i_raw (w_raw[g]),
                .o_rise(w_rise[g])
            );

            assign w_accept[g] = w_rise[g] & c_cfg_ok;

            // Pedestrian holds its pulse back whenever emergency is issuing on the same edge
            if (g == c_ch_ped) begin : g_yield
                assign w_hold = w_enter_issue[c_ch_emg];
            end else begin : g_lead
                assign w_hold = 1'b0;
            end

`ifdef TRAFFIC_REQ_RETRY_EN
            localparam logic [15:0] c_retry_last  = 16'(RETRY_CYCLES - 1);
            localparam logic [3:0]  c_max_retries = 4'(MAX_RETRIES);

            logic [15:0] r_wait_cnt;
            logic [3:0]  r_retries;
            logic        r_fault;
            logic        w_timeout;

            assign w_timeout = (r_state == WAIT) && !w_light[g] && (r_wait_cnt == c_retry_last);
            assign w_reissue = w_timeout && (r_retries != c_max_retries);
            assign w_give_up = w_timeout && (r_retries == c_max_retries);

            // Time the unanswered wait, count re-issues and latch the fault
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_wait_cnt <= 16'd0;
                    r_retries  <= 4'd0;
                    r_fault    <= 1'b0;
                end else begin
                    if (r_state == ISSUE) begin
                        r_wait_cnt <= 16'd0;
                    end else if ((r_state == WAIT) && !w_timeout) begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                    end
                    if ((r_state == IDLE) && w_accept[g]) begin
                        r_retries <= 4'd0;
                    end else if (w_reissue) begin
                        r_retries <= r_retries + 4'd1;
                    end
                    if (w_give_up) begin
                        r_fault <= 1'b1;
                    end
                end
            end

            assign w_fault[g] = r_fault;
`else
            assign w_reissue  = 1'b0;
            assign w_give_up  = 1'b0;
            assign w_fault[g] = 1'b0;
`endif

            assign w_enter_issue[g] = ((r_state == IDLE) && w_accept[g]) || w_reissue;

            // Request life cycle with registered button and pending outputs
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_state   <= IDLE;
                    r_button  <= 1'b0;
                    r_pending <= 1'b0;
                end else begin
                    case (r_state)
                        IDLE: begin
                            if (w_accept[g]) begin
                                r_state   <= ISSUE;
                                r_pending <= 1'b1;
                                r_button  <= !w_hold;
                            end
                        end
                        ISSUE: begin
                            if (r_button) begin
                                r_state  <= WAIT;
                                r_button <= 1'b0;
                            end else begin
                                r_button <= !w_hold;
                            end
                        end
                        WAIT: begin
                            if (w_light[g]) begin
                                r_state   <= SERVED;
                                r_pending <= 1'b0;
                            end else if (w_reissue) begin
                                r_state  <= ISSUE;
                                r_button <= !w_hold;
                            end else if (w_give_up) begin
                                r_state   <= IDLE;
                                r_pending <= 1'b0;
                            end
                        end
                        SERVED: begin
                            if (!w_light[g]) begin
                                r_state <= IDLE;
                            end
                        end
                        default: begin
                            r_state <= IDLE;
                        end
                    endcase
                end
            end

            assign w_button[g]  = r_button;
            assign w_pending[g] = r_pending;
        end
    endgenerate

    assign pedestrian_button = w_button[c_ch_ped];
    assign emergency_button  = w_button[c_ch_emg];
    assign ped_pending       = w_pending[c_ch_ped];
    assign emg_pending       = w_pending[c_ch_emg];
    assign req_fault         = w_fault;

endmodule
`default_nettype wire

// File: doc/traffic_request_ctrl.md
TRAFFIC_REQUEST_CTRL -- requirements
Module: traffic_request_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable synced samples needed to accept a raw press (range 1..255).
REQ-002 SHALL have parameter RETRY_CYCLES, default 400: cycles spent in WAIT before a re-issue pulse (range 2..65535).
REQ-003 SHALL have parameter MAX_RETRIES, default 3: re-issues allowed before fault (range 1..15).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 ped_raw  input  1  asynchronous raw pedestrian push-button.
REQ-007 emg_raw  input  1  asynchronous raw emergency push-button.
REQ-008 pedestrian_light  input  1  controller's pedestrian service indication.
REQ-009 emergency_light  input  1  controller's emergency service indication.
REQ-010 pedestrian_button  output  1  one-cycle request pulse to the traffic controller.
REQ-011 emergency_button  output  1  one-cycle request pulse to the traffic controller.
REQ-012 ped_pending / emg_pending  output  1 each  request accepted and not yet served.
REQ-013 req_fault  output  2  sticky fault, bit0 = pedestrian, bit1 = emergency.

Function
REQ-014 Each raw input SHALL pass through a 2-flop synchronizer, then a debouncer; a press SHALL be accepted on the debounced rising edge only.
REQ-015 Accept-to-pulse latency SHALL be exactly DEBOUNCE_CYCLES+3 rising edges from the first edge sampling raw high (7 at default).
REQ-016 Each channel SHALL run the FSM IDLE -> ISSUE -> WAIT -> SERVED -> IDLE.
REQ-017 IDLE: an accepted press SHALL go to ISSUE and set pending.
REQ-018 ISSUE: the button output SHALL be high for exactly one cycle, then the FSM SHALL go to WAIT with the retry counter cleared.
REQ-019 WAIT: a sampled light = 1 SHALL go to SERVED; light already high on WAIT entry SHALL count as served.
REQ-020 SERVED: pending SHALL clear on SERVED entry; return to IDLE when light samples 0.
REQ-021 A press accepted while the channel is not IDLE SHALL be merged and discarded, with no extra pulse.
REQ-022 When both channels enter ISSUE in the same cycle, emergency_button SHALL pulse first and pedestrian_button SHALL pulse on the next cycle; the two outputs SHALL never be high together.
REQ-023 The retry counter SHALL be 16-bit and reset on every ISSUE.

Reset
REQ-024 Reset SHALL clear all outputs to 0, all FSMs to IDLE, counters and synchronizers to 0, and req_fault to 2'b00.
REQ-025 Reset mid-operation SHALL drop any pending request without emitting a pulse; a press held through reset release SHALL need a full new debounce.

Configuration
REQ-026 Macro TRAFFIC_REQ_RETRY_EN defined: after RETRY_CYCLES in WAIT without light, the FSM SHALL return to ISSUE; after MAX_RETRIES re-issues it SHALL set its req_fault bit, clear pending and go to IDLE.
REQ-027 Macro TRAFFIC_REQ_RETRY_EN undefined: WAIT SHALL hold indefinitely with one pulse per request, req_fault SHALL be tied to 0, and no retry counter SHALL be synthesized.

Structure
REQ-028 Package traffic_pkg SHALL hold the channel state enum (IDLE, ISSUE, WAIT, SERVED) and the default timing constants.
REQ-029 Sub-module traffic_debounce (synchronizer + stable counter + rising-edge detect) SHALL be instantiated once per channel.

Verification
REQ-030 Reset for 1 cycle, ped_raw high 20 cycles -> exactly one pedestrian_button pulse 7 cycles after the rise; ped_pending = 1.
REQ-031 ped_raw toggling every 2 cycles for 30 cycles -> no pulse, ped_pending = 0.
REQ-032 emg_raw and ped_raw rise on the same edge -> emergency_button at cycle 7, pedestrian_button at cycle 8, never overlapping.
REQ-033 After the pulse, drive pedestrian_light high 5 cycles later -> ped_pending clears the next edge; a second press during the light -> no pulse.
REQ-034 TRAFFIC_REQ_RETRY_EN defined, RETRY_CYCLES = 10, lights held 0 -> 4 emergency pulses 11 cycles apart, then req_fault = 2'b10 and emg_pending = 0.
REQ-035 Assert reset during WAIT -> all outputs 0 within the same cycle; no pulse after release until a new press debounces.
